// File: rtl/btn_event_conditioner.sv
// N-channel button front end: per channel a 2-FF synchroniser, counter debounce and
// press / release / long-press / auto-repeat event pulses, all outputs registered.

module btn_channel #(
    parameter int DB_CYCLES     = 4,
    parameter int LONG_CYCLES   = 20,
    parameter int REPEAT_CYCLES = 5,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_evt,
    output logic rep_evt,
    output logic press_nxt
);
    localparam int DB_W     = $clog2(DB_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_REP  = HOLD_W'(REPEAT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_e;

    state_e              state_q, state_d;
    logic                sync0_q, sync0_d, sync1_q, sync1_d;
    logic                stable_q, stable_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                press_q, press_d, rel_q, rel_d;
    logic                long_q, long_d, rep_q, rep_d;
    logic                accept, rise, fall;

    always_comb begin
        sync0_d    = btn;
        sync1_d    = sync0_q;
        stable_d   = stable_q;
        db_cnt_d   = '0;
        hold_cnt_d = hold_cnt_q;
        state_d    = state_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        long_d     = 1'b0;
        rep_d      = 1'b0;
        accept     = 1'b0;

        // Any sample matching the stable level restarts the count, so bounce never accumulates.
        if (sync1_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync1_q;
                accept   = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
        rise = accept & sync1_q;
        fall = accept & ~sync1_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d    = ST_HELD;
                    press_d    = 1'b1;
                    hold_cnt_d = HOLD_ONE;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d    = ST_IDLE;
                    rel_d      = 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LONG) begin
                    state_d    = ST_LONG;
                    long_d     = 1'b1;
                    hold_cnt_d = HOLD_ONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            ST_LONG: begin
                // A release on the same cycle as a due repeat suppresses the repeat.
                if (fall) begin
                    state_d    = ST_IDLE;
                    rel_d      = 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_REP) begin
                    rep_d      = (REPEAT_EN != 0);
                    hold_cnt_d = HOLD_ONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync0_q    <= 1'b0;
            sync1_q    <= 1'b0;
            stable_q   <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            long_q     <= 1'b0;
            rep_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
            rep_q      <= rep_d;
        end
    end

    assign level     = stable_q;
    assign press     = press_q;
    assign rel       = rel_q;
    assign long_evt  = long_q;
    assign rep_evt   = rep_q;
    assign press_nxt = press_d & ~rst;
endmodule

module btn_event_conditioner #(
    parameter int NUM_BTN       = 4,
    parameter int DB_CYCLES     = 4,
    parameter int LONG_CYCLES   = 20,
    parameter int REPEAT_CYCLES = 5,
    parameter int REPEAT_EN     = 1
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [NUM_BTN-1:0] iBtn,
    input  logic [NUM_BTN-1:0] iMask,
    output logic [NUM_BTN-1:0] oLevel,
    output logic [NUM_BTN-1:0] oPress,
    output logic [NUM_BTN-1:0] oRelease,
    output logic [NUM_BTN-1:0] oLong,
    output logic [NUM_BTN-1:0] oRepeat,
    output logic               oAnyPress
);
    logic [NUM_BTN-1:0] press_nxt;
    logic               any_press_q, any_press_d;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        // Mask reuses the channel reset path: state clears silently, no release pulse.
        btn_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN)
        ) u_ch (
            .clk       (iClk),
            .rst       (iRst | iMask[gi]),
            .btn       (iBtn[gi]),
            .level     (oLevel[gi]),
            .press     (oPress[gi]),
            .rel       (oRelease[gi]),
            .long_evt  (oLong[gi]),
            .rep_evt   (oRepeat[gi]),
            .press_nxt (press_nxt[gi])
        );
    end

    always_comb begin
        any_press_d = |press_nxt;
    end

    always_ff @(posedge iClk) begin
        if (iRst) any_press_q <= 1'b0;
        else      any_press_q <= any_press_d;
    end

    assign oAnyPress = any_press_q;
endmodule

// File: tb/tb_btn_event_conditioner.sv
// Directed bench for btn_event_conditioner: default instance plus a REPEAT_EN=0 twin
// driven by the same stimulus.

module tb_btn_event_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] mask;
    logic [3:0] a_level, a_press, a_rel, a_long, a_rep;
    logic [3:0] b_level, b_press, b_rel, b_long, b_rep;
    logic       a_any, b_any;
    logic       b_rep_seen = 1'b0;
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    btn_event_conditioner dut_a (
        .iClk(clk), .iRst(rst), .iBtn(btn), .iMask(mask),
        .oLevel(a_level), .oPress(a_press), .oRelease(a_rel),
        .oLong(a_long), .oRepeat(a_rep), .oAnyPress(a_any)
    );

    btn_event_conditioner #(.REPEAT_EN(0)) dut_b (
        .iClk(clk), .iRst(rst), .iBtn(btn), .iMask(mask),
        .oLevel(b_level), .oPress(b_press), .oRelease(b_rel),
        .oLong(b_long), .oRepeat(b_rep), .oAnyPress(b_any)
    );

    always @(negedge clk) if (b_rep != 4'b0) b_rep_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each tick returns 1 time unit after a rising edge: outputs of that edge are visible.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        logic [3:0] acc_a, acc_b, acc_c;
        int         extra;

        // 1. reset and latency
        rst = 1'b1; btn = 4'hF; mask = 4'h0;
        ticks(3);
        chk("rst_level", a_level, 0);
        chk("rst_press", a_press, 0);
        chk("rst_rel",   a_rel,   0);
        chk("rst_long",  a_long,  0);
        chk("rst_rep",   a_rep,   0);
        chk("rst_any",   a_any,   0);
        rst = 1'b0; btn = 4'h0;
        ticks(8);
        btn[0] = 1'b1;
        ticks(5);
        chk("t1_pre_lvl",   a_level[0], 0);
        chk("t1_pre_press", a_press[0], 0);
        tick();
        chk("t1_lvl",   a_level[0], 1);
        chk("t1_press", a_press[0], 1);
        chk("t1_any",   a_any, 1);
        tick();
        chk("t1_press_w", a_press[0], 0);
        chk("t1_lvl_hold", a_level[0], 1);
        btn[0] = 1'b0;
        ticks(5);
        chk("t1_rel_pre", a_rel[0], 0);
        tick();
        chk("t1_rel", a_rel[0], 1);
        chk("t1_rel_lvl", a_level[0], 0);
        tick();
        chk("t1_rel_w", a_rel[0], 0);

        // 2. bounce on channel 1: 3 high / 2 low never reaches 4 stable samples
        acc_a = '0; acc_b = '0;
        for (int c = 0; c < 8; c++) begin
            btn[1] = 1'b1;
            for (int j = 0; j < 3; j++) begin tick(); acc_a |= a_press; acc_b |= a_level; end
            btn[1] = 1'b0;
            for (int j = 0; j < 2; j++) begin tick(); acc_a |= a_press; acc_b |= a_level; end
        end
        chk("t2_no_press", acc_a[1], 0);
        chk("t2_no_level", acc_b[1], 0);
        btn[1] = 1'b1;
        ticks(5);
        chk("t2_pre_press", a_press[1], 0);
        tick();
        chk("t2_press", a_press[1], 1);
        extra = 0;
        for (int j = 0; j < 10; j++) begin tick(); if (a_press[1]) extra++; end
        chk("t2_single", extra, 0);
        btn[1] = 1'b0;
        ticks(10);

        // 3. long + repeat on channel 2, released after 60 held cycles
        btn[2] = 1'b1;
        ticks(6);
        chk("t3_press", a_press[2], 1);
        for (int k = 1; k <= 90; k++) begin
            tick();
            chk("t3_long",  a_long[2], (k == 20));
            chk("t3_rep",   a_rep[2],  (k > 20 && k < 66 && ((k - 20) % 5) == 0));
            chk("t3_rel",   a_rel[2],  (k == 66));
            chk("t3_lvl",   a_level[2], (k < 66));
            chk("t3_blong", b_long[2], (k == 20));
            chk("t3_brep",  b_rep[2], 0);
            if (k == 60) btn[2] = 1'b0;
        end

        // 4. release lands on the long-press cycle: release wins
        btn[0] = 1'b1;
        ticks(6);
        chk("t4_press", a_press[0], 1);
        ticks(14);
        btn[0] = 1'b0;
        ticks(6);
        chk("t4_rel",   a_rel[0], 1);
        chk("t4_long",  a_long[0], 0);
        chk("t4_blong", b_long[0], 0);
        tick();
        chk("t4_long_after", a_long[0], 0);
        chk("t4_rel_w", a_rel[0], 0);
        ticks(4);

        // 5. mask channel 3 while in LONG
        btn[3] = 1'b1;
        ticks(6);
        chk("t5_press", a_press[3], 1);
        ticks(22);
        chk("t5_in_long", a_level[3], 1);
        mask[3] = 1'b1;
        tick();
        chk("t5_m_lvl",  a_level[3], 0);
        chk("t5_m_rel",  a_rel[3], 0);
        chk("t5_m_long", a_long[3], 0);
        chk("t5_m_rep",  a_rep[3], 0);
        chk("t5_m_press", a_press[3], 0);
        acc_a = '0;
        for (int j = 0; j < 9; j++) begin
            tick();
            acc_a |= a_level | a_press | a_rel | a_long | a_rep;
        end
        chk("t5_m_quiet", acc_a[3], 0);
        mask[3] = 1'b0;
        ticks(5);
        chk("t5_un_pre", a_press[3], 0);
        tick();
        chk("t5_un_press", a_press[3], 1);
        btn[3] = 1'b0;
        ticks(10);

        // 6. simultaneous press on channels 0 and 3
        btn = 4'b1001;
        ticks(5);
        chk("t6_pre", a_press, 0);
        tick();
        chk("t6_press",  a_press, 4'b1001);
        chk("t6_any",    a_any, 1);
        chk("t6_bpress", b_press, 4'b1001);
        tick();
        chk("t6_press_w", a_press, 0);
        chk("t6_any_w",   a_any, 0);
        acc_a = '0; acc_b = '0; acc_c = '0;
        for (int j = 0; j < 39; j++) begin
            tick();
            acc_a |= a_rep; acc_b |= b_long; acc_c |= b_rep;
        end
        chk("t6_arep",  acc_a, 4'b1001);
        chk("t6_blong", acc_b, 4'b1001);
        chk("t6_brep",  acc_c, 0);
        btn = 4'h0;
        ticks(10);
        chk("rep_en0", b_rep_seen, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
